// File: rtl/auth_sequencer_if.sv
// Key byte stream between the pin-level decode and the authentication FSM.
// Latency: none, wires only.
// Backpressure: byte_ready from the slave qualifies byte_valid; a byte moves when both are high.
// Signals: byte_in (key byte), byte_valid (byte_in valid), byte_ready (sink can accept).
interface auth_sequencer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/auth_sequencer.sv
// Authentication control FSM: collects KEY_BYTES key bytes, compares them
// serially against SECRET, grants/denies, counts failures, enforces lockout.
// Latency: last byte accepted at cycle N -> CHECK at N+1 -> auth_ok/deny at N+2.
// Backpressure: byte_ready is high only in COLLECT; every byte is consumed even after a mismatch.
// Ports: clk, rst_n (async assert, released through a 2-flop synchronizer),
//   start, logout, key_if (byte stream slave), busy, auth_ok, deny, locked,
//   fail_cnt (consecutive failures), state_o (IDLE=0 COLLECT=1 CHECK=2 GRANT=3 DENY=4 LOCKOUT=5).
module auth_sequencer #(
  parameter int                     KEY_BYTES      = 4,
  parameter logic [8*KEY_BYTES-1:0] SECRET         = 32'hA5C3_1E7B,
  parameter int                     MAX_FAIL       = 3,
  parameter int                     LOCK_CYCLES    = 1024,
  parameter int                     TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   logout,
  auth_sequencer_if.slave        key_if,
  output logic                   busy,
  output logic                   auth_ok,
  output logic                   deny,
  output logic                   locked,
  output logic [2:0]             fail_cnt,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_GRANT   = 3'd3,
    S_DENY    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  // Counter widths; each counter stops at its limit-1 so it never wraps.
  localparam int IW = (KEY_BYTES      > 1) ? $clog2(KEY_BYTES)      : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (LOCK_CYCLES    > 1) ? $clog2(LOCK_CYCLES)    : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(KEY_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    FAIL_MAX = 3'(MAX_FAIL);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          mis, mis_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic [LW-1:0] lck, lck_nxt;
  logic [2:0]    fail_nxt;
  logic [2:0]    fail_inc;
  logic [7:0]    sec_byte;

  // Byte 0 of the key is the most significant byte of SECRET.
  always_comb begin
    sec_byte = 8'h00;
    for (int i = 0; i < KEY_BYTES; i++) begin
      if (idx == IW'(i)) sec_byte = SECRET[8*(KEY_BYTES-1-i) +: 8];
    end
  end

  assign fail_inc = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      mis      <= 1'b0;
      tmo      <= '0;
      lck      <= '0;
      fail_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      mis      <= mis_nxt;
      tmo      <= tmo_nxt;
      lck      <= lck_nxt;
      fail_cnt <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mis_nxt   = mis;
    tmo_nxt   = tmo;
    lck_nxt   = lck;
    fail_nxt  = fail_cnt;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_COLLECT;
          idx_nxt   = '0;
          mis_nxt   = 1'b0;
          tmo_nxt   = '0;
        end
      end

      S_COLLECT: begin
        // logout wins over both a same-cycle byte and the idle timeout.
        if (logout) begin
          state_nxt = S_IDLE;
        end else if (key_if.byte_valid) begin
          // Mismatch is only recorded; collection always runs to the last byte.
          mis_nxt = mis | (key_if.byte_in != sec_byte);
          tmo_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = S_CHECK;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else if (tmo == TMO_LAST) begin
          state_nxt = S_DENY;
          tmo_nxt   = '0;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end

      S_CHECK: begin
        if (mis) begin
          state_nxt = S_DENY;
        end else begin
          state_nxt = S_GRANT;
          fail_nxt  = 3'd0;
        end
      end

      S_GRANT: begin
        if (logout) state_nxt = S_IDLE;
      end

      S_DENY: begin
        // The incremented count is visible from the cycle after the deny pulse.
        fail_nxt = fail_inc;
        if (fail_inc == FAIL_MAX) begin
          state_nxt = S_LOCKOUT;
          lck_nxt   = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        if (lck == LCK_LAST) begin
          state_nxt = S_IDLE;
          lck_nxt   = '0;
          fail_nxt  = 3'd0;
        end else begin
          lck_nxt = lck + 1'b1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // All status outputs decode the state register only.
  assign key_if.byte_ready = (state == S_COLLECT);
  assign busy              = (state == S_COLLECT) || (state == S_CHECK);
  assign auth_ok           = (state == S_GRANT);
  assign deny              = (state == S_DENY);
  assign locked            = (state == S_LOCKOUT);
  assign state_o           = state;

endmodule

// File: tb/tb_auth_sequencer.sv
// Directed bench for auth_sequencer: grant, deny, lockout, timeout, abort, reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_auth_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       logout = 1'b0;
  logic       busy, auth_ok, deny, locked;
  logic [2:0] fail_cnt, state_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] KEY_OK = 32'hA5C3_1E7B;

  auth_sequencer_if kif ();

  auth_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .logout   (logout),
    .key_if   (kif),
    .busy     (busy),
    .auth_ok  (auth_ok),
    .deny     (deny),
    .locked   (locked),
    .fail_cnt (fail_cnt),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    kif.byte_in    = b;
    kif.byte_valid = 1'b1;
    tick();
    kif.byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Full attempt; returns one cycle after CHECK, i.e. in GRANT or DENY.
  task automatic run_key(input logic [31:0] key);
    start = 1'b1;
    tick();
    start = 1'b0;
    kif.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kif.byte_in = key[31-8*i -: 8];
      tick();
    end
    kif.byte_valid = 1'b0;
    tick();
  endtask

  initial begin
    int k;
    kif.byte_in    = 8'h00;
    kif.byte_valid = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_state", state_o, 3'd0);
    check("rst_ready", kif.byte_ready, 1'b0);
    check("rst_fail", fail_cnt, 3'd0);
    check("rst_outs", {busy, auth_ok, deny, locked}, 4'b0000);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_state", state_o, 3'd0);

    // Correct key, back-to-back
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ok_collect", state_o, 3'd1);
    check("ok_ready", kif.byte_ready, 1'b1);
    check("ok_busy", busy, 1'b1);
    kif.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kif.byte_in = KEY_OK[31-8*i -: 8];
      tick();
    end
    kif.byte_valid = 1'b0;
    check("ok_check_state", state_o, 3'd2);
    check("ok_check_ready", kif.byte_ready, 1'b0);
    check("ok_check_auth", auth_ok, 1'b0);
    tick();
    check("ok_auth", auth_ok, 1'b1);
    check("ok_state", state_o, 3'd3);
    check("ok_fail", fail_cnt, 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("grant_ignores_start", state_o, 3'd3);
    logout = 1'b1;
    tick();
    logout = 1'b0;
    check("logout_state", state_o, 3'd0);
    check("logout_auth", auth_ok, 1'b0);

    // Wrong first byte with 2-cycle gaps
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h00, 2);
    send_byte(8'hC3, 2);
    send_byte(8'h1E, 2);
    send_byte(8'h7B, 0);
    check("bad1_check", state_o, 3'd2);
    tick();
    check("bad1_deny", deny, 1'b1);
    check("bad1_auth", auth_ok, 1'b0);
    tick();
    check("bad1_deny_pulse", deny, 1'b0);
    check("bad1_fail", fail_cnt, 3'd1);
    check("bad1_state", state_o, 3'd0);

    // Two more failures -> lockout
    run_key(32'hA5C3_1E7A);
    check("bad2_deny", deny, 1'b1);
    tick();
    check("bad2_fail", fail_cnt, 3'd2);
    check("bad2_state", state_o, 3'd0);
    run_key(32'hFFC3_1E7B);
    check("bad3_deny", deny, 1'b1);
    tick();
    check("lock_locked", locked, 1'b1);
    check("lock_state", state_o, 3'd5);
    check("lock_fail", fail_cnt, 3'd3);
    start = 1'b1;
    logout = 1'b1;
    kif.byte_valid = 1'b1;
    repeat (1023) tick();
    check("lock_hold", locked, 1'b1);
    start = 1'b0;
    logout = 1'b0;
    kif.byte_valid = 1'b0;
    tick();
    check("lock_release", locked, 1'b0);
    check("lock_rel_state", state_o, 3'd0);
    check("lock_rel_fail", fail_cnt, 3'd0);
    run_key(KEY_OK);
    check("post_lock_grant", auth_ok, 1'b1);
    logout = 1'b1;
    tick();
    logout = 1'b0;

    // Timeout after one byte
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'hA5, 0);
    k = 0;
    while (!deny && k < 300) begin
      tick();
      k++;
    end
    check("tmo_cycles", k, 256);
    check("tmo_deny", deny, 1'b1);
    tick();
    check("tmo_fail", fail_cnt, 3'd1);
    check("tmo_state", state_o, 3'd0);

    // logout after two bytes
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'hC3, 0);
    logout = 1'b1;
    tick();
    logout = 1'b0;
    check("abort_state", state_o, 3'd0);
    check("abort_deny", deny, 1'b0);
    check("abort_fail", fail_cnt, 3'd1);

    // logout beats the final byte
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h1E, 0);
    kif.byte_in    = 8'h7B;
    kif.byte_valid = 1'b1;
    logout         = 1'b1;
    tick();
    kif.byte_valid = 1'b0;
    logout         = 1'b0;
    check("prio_state", state_o, 3'd0);
    tick();
    check("prio_no_deny", deny, 1'b0);
    check("prio_fail", fail_cnt, 3'd1);

    // Reset mid-COLLECT
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'hA5, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstc_state", state_o, 3'd0);
    check("rstc_outs", {kif.byte_ready, busy, auth_ok, deny, locked}, 5'b00000);
    check("rstc_fail", fail_cnt, 3'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rstc_rel_state", state_o, 3'd0);
    check("rstc_rel_fail", fail_cnt, 3'd0);

    // Reset mid-LOCKOUT
    run_key(32'h0000_0000);
    tick();
    run_key(32'h0000_0000);
    tick();
    run_key(32'h0000_0000);
    tick();
    check("rstl_locked", locked, 1'b1);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstl_outs", {kif.byte_ready, busy, auth_ok, deny, locked}, 5'b00000);
    check("rstl_state", state_o, 3'd0);
    check("rstl_fail", fail_cnt, 3'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rstl_rel_state", state_o, 3'd0);
    check("rstl_rel_fail", fail_cnt, 3'd0);
    run_key(KEY_OK);
    check("rstl_grant", auth_ok, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/auth_sequencer.md
Name: auth_sequencer

Overview:
- Control FSM for the tiny hardware authentication design.
- Collects a multi-byte key over a valid/ready byte stream and compares it byte-serially against a fixed secret.
- Grants or denies access, counts consecutive failures, and enforces a timed lockout.
- Sits between the pin-level wrapper (ui_in/uio_in decode) and the status outputs (uo_out).

Parameters:
- KEY_BYTES, 4, number of key bytes per attempt (1..8).
- SECRET, 32'hA5C3_1E7B, expected key; byte 0 = most significant byte; width = 8*KEY_BYTES.
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..7).
- LOCK_CYCLES, 1024, lockout duration in clk cycles.
- TIMEOUT_CYCLES, 256, maximum idle gap between accepted bytes during collection.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin attempt; sampled only in IDLE.
- logout, input, 1, leave GRANT or abort COLLECT; ignored elsewhere.
- byte_in, input, 8, key byte.
- byte_valid, input, 1, byte_in is valid.
- byte_ready, output, 1, high only in COLLECT.
- busy, output, 1, high in COLLECT and CHECK.
- auth_ok, output, 1, level; high only in GRANT.
- deny, output, 1, single-cycle pulse on each failed attempt.
- locked, output, 1, high only in LOCKOUT.
- fail_cnt, output, 3, current consecutive-failure count.
- state_o, output, 3, encoding: IDLE=0, COLLECT=1, CHECK=2, GRANT=3, DENY=4, LOCKOUT=5.

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE; all outputs 0; fail_cnt=0.
  - byte index, mismatch flag, timeout counter and lock counter cleared.
  - Applies in any state, including mid-collection and mid-lockout.
- Outputs are registered or decoded from the state register only, with no combinational path from inputs.
- IDLE:
  - start=1 -> COLLECT next cycle; idx=0, mismatch=0, tmo=0.
- COLLECT:
  - byte_ready=1.
  - Accept when byte_valid & byte_ready:
    - mismatch |= (byte_in != SECRET byte idx); idx++; tmo=0.
    - No early exit on mismatch: all KEY_BYTES bytes are always consumed (constant-time).
  - Acceptance of byte KEY_BYTES-1 -> CHECK; byte_ready drops the following cycle.
  - No accept: tmo++. When tmo reaches TIMEOUT_CYCLES-1 -> DENY (counts as failure).
  - logout=1 -> IDLE, no failure counted. logout has priority over a same-cycle accept and over timeout.
- CHECK (exactly 1 cycle):
  - mismatch=0 -> GRANT; otherwise -> DENY.
- GRANT:
  - auth_ok=1; fail_cnt cleared on entry.
  - Stays in GRANT until logout=1 -> IDLE. start is ignored.
- DENY (exactly 1 cycle):
  - deny=1; fail_cnt saturating increment.
  - If the new fail_cnt == MAX_FAIL -> LOCKOUT (lock counter=0); otherwise -> IDLE.
- LOCKOUT:
  - locked=1; start, logout and byte_valid are ignored.
  - Leaves after exactly LOCK_CYCLES cycles in LOCKOUT -> IDLE with fail_cnt=0.
- Latency:
  - Last byte accepted at cycle N -> CHECK at N+1 -> auth_ok or deny visible at N+2.
- Counters sized with $clog2 of their limits; wrap is impossible by construction.

Test Plan:
- Correct key: start, then bytes A5,C3,1E,7B back-to-back -> auth_ok=1 two cycles after the 7B accept; fail_cnt=0; logout -> state_o=0 next cycle.
- Wrong first byte: bytes 00,C3,1E,7B with 2-cycle gaps between bytes -> all 4 bytes accepted; one-cycle deny pulse; fail_cnt=1; state IDLE; auth_ok stays 0.
- Three wrong attempts (MAX_FAIL=3) -> locked=1 after the third deny. start during lockout is ignored. locked falls exactly 1024 cycles later; fail_cnt=0. A correct key then grants access.
- Timeout: start, one byte A5, then byte_valid=0 -> deny pulse when tmo reaches 255; fail_cnt=1.
- Abort and priority:
  - logout during COLLECT after 2 bytes -> IDLE, no deny, fail_cnt unchanged.
  - logout together with byte_valid on the last byte -> IDLE, not CHECK.
- Reset mid-operation: assert rst_n=0 asynchronously mid-COLLECT and separately mid-LOCKOUT -> all outputs 0 immediately; state_o=0, fail_cnt=0 after release.
